// File: rtl/fm_pingpong_buffer_pkg.sv
// ============================================================================
// fm_pingpong_buffer_pkg : shared feature-map parameters and bank state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package fm_pingpong_buffer_pkg;
  localparam int FM_DATA_WIDTH = 16;
  localparam int FM_PARA_X     = 3;
  localparam int FM_PARA_Y     = 3;
  localparam int FM_ADDR_WIDTH = 6;
  localparam int FM_DEPTH      = 18;
  localparam int FM_WORD_WIDTH = FM_PARA_X * FM_PARA_Y * FM_DATA_WIDTH;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;
endpackage

`default_nettype wire

// File: rtl/fm_bank_ram.sv
// ============================================================================
// fm_bank_ram : simple dual-port RAM, one write port, one registered read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module fm_bank_ram
  import fm_pingpong_buffer_pkg::*;
#(
  parameter int WIDTH = FM_WORD_WIDTH,
  parameter int DEPTH = FM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

`default_nettype wire

// File: rtl/fm_pingpong_buffer.sv
// ============================================================================
// fm_pingpong_buffer : captures init-stream frames into two ping-pong banks
//                      and presents the completed bank for random reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module fm_pingpong_buffer
  import fm_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = FM_DATA_WIDTH,
  parameter int PARA_X     = FM_PARA_X,
  parameter int PARA_Y     = FM_PARA_Y,
  parameter int ADDR_WIDTH = FM_ADDR_WIDTH,
  parameter int DEPTH      = FM_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic                                wr_done,
  input  logic                                rd_en,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic                                release_pulse, // "release" is a reserved word
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] rd_data,
  output logic                                rd_valid,
  output logic                                bank_ready,
  output logic                                rd_bank,
  output logic [ADDR_WIDTH:0]                 fill_count,
  output logic                                wr_stall,
  output logic                                drop_err,
  output logic                                addr_err
);
  localparam int                    WORD_W  = PARA_X * PARA_Y * DATA_WIDTH;
  localparam int                    RAM_AW  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  bank_state_e           bank_st_q [2], bank_st_d [2];
  logic [ADDR_WIDTH:0]   bank_fill_q [2], bank_fill_d [2];
  logic [ADDR_WIDTH-1:0] cur_max_q, cur_max_d;
  logic                  cur_any_q, cur_any_d;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                  wr_done_q, rd_sel_q, rd_sel_d;
  logic                  bank_ready_q, bank_ready_d, wr_stall_q, wr_stall_d;
  logic                  drop_err_q, drop_err_d, addr_err_q, addr_err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH:0]   fill_count_q, fill_count_d;
  logic [WORD_W-1:0]     ram_rdata [2];

  logic frame_start, frame_end, filling, wr_in_range, rd_in_range, wr_fire, rd_fire, do_release;

  assign frame_start = !wr_done && wr_done_q;
  assign frame_end   = wr_done && !wr_done_q;
  // The start cycle already carries a valid word, so it writes alongside FILLING cycles.
  assign filling     = !wr_done && (bank_st_q[wr_bank_q] == BANK_FILLING ||
                                    (frame_start && bank_st_q[wr_bank_q] == BANK_EMPTY));
  assign wr_in_range = wr_addr < DEPTH_A;
  assign rd_in_range = rd_addr < DEPTH_A;
  assign wr_fire     = filling && wr_in_range && !rst;
  assign rd_fire     = rd_en && bank_ready_q && rd_in_range;
  assign do_release  = release_pulse && bank_ready_q;

  always_comb begin
    bank_st_d   = bank_st_q;
    bank_fill_d = bank_fill_q;
    cur_max_d   = cur_max_q;
    cur_any_d   = cur_any_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_sel_d    = rd_sel_q;
    drop_err_d  = drop_err_q;
    addr_err_d  = addr_err_q;
    rd_valid_d  = rd_fire;

    if (frame_start && bank_st_q[wr_bank_q] == BANK_EMPTY) begin
      bank_st_d[wr_bank_q] = BANK_FILLING;
      cur_max_d            = '0;
      cur_any_d            = 1'b0;
    end else if (frame_start) begin
      drop_err_d = 1'b1;
    end

    if (wr_fire) begin
      if (!cur_any_d || wr_addr > cur_max_d) cur_max_d = wr_addr;
      cur_any_d = 1'b1;
    end
    if ((filling && !wr_in_range) || (rd_en && !rd_in_range)) addr_err_d = 1'b1;

    // A dropped frame never owns the bank, so only a FILLING bank completes.
    if (frame_end && bank_st_q[wr_bank_q] == BANK_FILLING) begin
      bank_st_d[wr_bank_q]   = BANK_FULL;
      bank_fill_d[wr_bank_q] = cur_any_q ? ({1'b0, cur_max_q} + 1'b1) : '0;
      wr_bank_d              = !wr_bank_q;
    end

    if (do_release) begin
      bank_st_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d            = !rd_bank_q;
    end

    if (rd_fire) rd_sel_d = rd_bank_q;

    bank_ready_d = bank_st_d[rd_bank_d] == BANK_FULL;
    fill_count_d = bank_ready_d ? bank_fill_d[rd_bank_d] : '0;
    wr_stall_d   = bank_st_d[wr_bank_d] != BANK_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q    <= '{BANK_EMPTY, BANK_EMPTY};
      bank_fill_q  <= '{'0, '0};
      cur_max_q    <= '0;
      cur_any_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_done_q    <= 1'b1;
      rd_sel_q     <= 1'b0;
      bank_ready_q <= 1'b0;
      wr_stall_q   <= 1'b0;
      drop_err_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      fill_count_q <= '0;
    end else begin
      bank_st_q    <= bank_st_d;
      bank_fill_q  <= bank_fill_d;
      cur_max_q    <= cur_max_d;
      cur_any_q    <= cur_any_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_done_q    <= wr_done;
      rd_sel_q     <= rd_sel_d;
      bank_ready_q <= bank_ready_d;
      wr_stall_q   <= wr_stall_d;
      drop_err_q   <= drop_err_d;
      addr_err_q   <= addr_err_d;
      rd_valid_q   <= rd_valid_d;
      fill_count_q <= fill_count_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fm_bank_ram #(.WIDTH(WORD_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_fire && (wr_bank_q == 1'(b))),
      .waddr (wr_addr[RAM_AW-1:0]),
      .wdata (wr_data),
      .re    (rd_fire && (rd_bank_q == 1'(b))),
      .raddr (rd_addr[RAM_AW-1:0]),
      .rdata (ram_rdata[b])
    );
  end

  assign rd_data    = ram_rdata[rd_sel_q];
  assign rd_valid   = rd_valid_q;
  assign bank_ready = bank_ready_q;
  assign rd_bank    = rd_bank_q;
  assign fill_count = fill_count_q;
  assign wr_stall   = wr_stall_q;
  assign drop_err   = drop_err_q;
  assign addr_err   = addr_err_q;
endmodule

`default_nettype wire

// File: tb/tb_fm_pingpong_buffer.sv
// ============================================================================
// tb_fm_pingpong_buffer : scoreboard bench with a frame-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fm_pingpong_buffer;
  localparam int W  = 144;
  localparam int AW = 6;
  localparam int D  = 18;

  logic          clk = 1'b0;
  logic          rst, wr_done, rd_en, rel;
  logic [W-1:0]  wr_data, rd_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_valid, bank_ready, rd_bank, wr_stall, drop_err, addr_err;
  logic [AW:0]   fill_count;

  fm_pingpong_buffer dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .release_pulse(rel), .rd_data(rd_data),
    .rd_valid(rd_valid), .bank_ready(bank_ready), .rd_bank(rd_bank),
    .fill_count(fill_count), .wr_stall(wr_stall), .drop_err(drop_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Frame-level model: each bank is either holding a finished frame or free.
  logic [W-1:0] m_mem [2][D];
  bit           m_full [2];
  int           m_fill [2];
  bit           m_wb, m_rd, m_drop, m_aerr, m_acc;
  int           m_max;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, ".bank_ready"}, W'(bank_ready), W'(m_full[m_rd]));
    chk({tag, ".rd_bank"},    W'(rd_bank),    W'(m_rd));
    chk({tag, ".fill_count"}, W'(fill_count), W'(m_full[m_rd] ? m_fill[m_rd] : 0));
    chk({tag, ".wr_stall"},   W'(wr_stall),   W'(m_full[m_wb]));
    chk({tag, ".drop_err"},   W'(drop_err),   W'(m_drop));
    chk({tag, ".addr_err"},   W'(addr_err),   W'(m_aerr));
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, ".bank_ready"}, W'(bank_ready), '0);
    chk({tag, ".rd_bank"},    W'(rd_bank),    '0);
    chk({tag, ".fill_count"}, W'(fill_count), '0);
    chk({tag, ".wr_stall"},   W'(wr_stall),   '0);
    chk({tag, ".drop_err"},   W'(drop_err),   '0);
    chk({tag, ".addr_err"},   W'(addr_err),   '0);
    chk({tag, ".rd_valid"},   W'(rd_valid),   '0);
    chk({tag, ".rd_data"},    rd_data,        '0);
  endtask

  task automatic model_reset();
    m_full = '{0, 0};
    m_fill = '{0, 0};
    m_wb = 0; m_rd = 0; m_drop = 0; m_aerr = 0;
  endtask

  task automatic frame_begin();
    m_acc = !m_full[m_wb];
    m_max = -1;
    if (!m_acc) m_drop = 1;
  endtask

  task automatic write_word(input int a, input logic [W-1:0] d);
    wr_done = 1'b0; wr_addr = AW'(a); wr_data = d;
    step();
    step();
    if (m_acc && a < D) begin
      m_mem[m_wb][a] = d;
      if (a > m_max) m_max = a;
    end else if (m_acc) begin
      m_aerr = 1;
    end
  endtask

  task automatic frame_end(input bit rel_at_end);
    wr_done = 1'b1;
    rel = rel_at_end;
    step();
    rel = 1'b0;
    if (rel_at_end && m_full[m_rd]) begin
      m_full[m_rd] = 0;
      m_rd = !m_rd;
    end
    if (m_acc) begin
      m_full[m_wb] = 1;
      m_fill[m_wb] = m_max + 1;
      m_wb = !m_wb;
    end
  endtask

  task automatic send_frame(input int last, input bit addr_data, input bit shuffle,
                            input int bad_addr, input bit rel_at_end);
    int order [$];
    for (int i = 0; i <= last; i++) order.push_back(i);
    if (shuffle)
      for (int i = order.size() - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
    if (bad_addr >= 0) order.insert($urandom_range(0, order.size()), bad_addr);
    frame_begin();
    foreach (order[k]) write_word(order[k], addr_data ? {9{16'(order[k])}} : rand_word());
    frame_end(rel_at_end);
  endtask

  task automatic issue_read(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    if (a >= D) m_aerr = 1;
    else if (m_full[m_rd]) exp_q.push_back(m_mem[m_rd][a]);
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_reads(input int n, input bit allow_bad);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      else if (allow_bad && $urandom_range(0, 7) == 0) issue_read($urandom_range(D, 63));
      else issue_read($urandom_range(0, D - 1));
    end
  endtask

  task automatic do_release();
    rel = 1'b1;
    step();
    rel = 1'b0;
    if (m_full[m_rd]) begin
      m_full[m_rd] = 0;
      m_rd = !m_rd;
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expected word.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rd_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rd_data: got unexpected word %0h, want no rd_valid", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_done = 1'b1; rd_en = 1'b0; rel = 1'b0;
    wr_data = '0; wr_addr = '0; rd_addr = '0;
    model_reset();
    foreach (m_mem[b, a]) m_mem[b][a] = 'x;
    repeat (3) step();
    rst = 1'b0;
    check_zero("reset");

    // Single frame into bank 0, data = address replicated.
    send_frame(D - 1, 1'b1, 1'b0, -1, 1'b0);
    check_status("frame0");
    issue_read(5);
    @(negedge clk);
    chk("rd_latency.rd_valid", W'(rd_valid), W'(1));
    do_reads(20, 1'b0);

    // Second frame loads while bank 0 is being read.
    fork
      send_frame(D - 1, 1'b0, 1'b1, -1, 1'b0);
      do_reads(30, 1'b0);
    join
    check_status("pingpong");

    // Both banks occupied: third frame is dropped.
    send_frame(D - 1, 1'b0, 1'b0, -1, 1'b0);
    check_status("overflow");
    do_reads(25, 1'b0);
    do_release();
    check_status("release0");
    do_reads(25, 1'b0);

    // Short frame with an out-of-range write, then reads incl. bad addresses.
    send_frame(3, 1'b0, 1'b1, 20, 1'b0);
    check_status("short");
    do_release();
    check_status("release1");
    do_reads(20, 1'b1);
    issue_read(D);
    @(negedge clk);
    chk("rd_addr18.rd_valid", W'(rd_valid), W'(0));
    check_status("rdbad");

    // Frame end on bank 1 coincides with release of bank 0.
    send_frame(D - 1, 1'b0, 1'b1, -1, 1'b1);
    check_status("simul");
    do_reads(20, 1'b0);

    // Reset while address 9 of a new frame is on the bus.
    frame_begin();
    for (int a = 0; a < 9; a++) write_word(a, rand_word());
    wr_addr = AW'(9); wr_data = rand_word(); rst = 1'b1;
    step();
    wr_done = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_zero("midreset");
    send_frame(D - 1, 1'b0, 1'b1, -1, 1'b0);
    check_status("postreset");
    do_reads(20, 1'b0);

    // Random mix of operations.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0: send_frame($urandom_range(0, D - 1), 1'b0, 1'b1, -1, 1'b0);
        1: do_release();
        default: do_reads(10, 1'b1);
      endcase
      check_status("random");
    end

    repeat (3) step();
    chk("pending_reads", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

`default_nettype wire
